// File: rtl/data_req_win_pkg.sv
// Shared state encoding, inputshape field offsets and address type for the
// data_req_win convolution-window request generator.
package data_req_win_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG0 = 3'd1,
        ST_CFG1 = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int SHAPE_W_OFS = 0;
    localparam int SHAPE_H_OFS = 8;
    localparam int SHAPE_C_OFS = 16;

    localparam int ADDR_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/data_req_win_cnt.sv
// Generic wrap counter: counts 0..term_i while enabled, exposes its next value
// and a wrap flag that is high on the enabled cycle it sits at term_i.
module data_req_win_cnt
    import data_req_win_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == term_i);
    assign wrap_o  = en_i & at_term;
    assign nxt_o   = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_term ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_req_win.sv
// Convolution-window read-request generator (K x K kernel, stride S, HWC map).
// Optional debug counters are built when DATA_REQ_WIN_DBG_EN is defined.
module data_req_win
    import data_req_win_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int REG_WIDTH    = 32,
    parameter int DIM_WIDTH    = 8,
    parameter int KSIZE_WIDTH  = 3,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_clear,
    input  logic                    i_stall,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [REG_WIDTH-1:0]    i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]    i_conf_kernelshape,
    input  logic [STRIDE_WIDTH-1:0] i_cnfx_stride,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic                    o_rden,
    output logic                    o_win_last,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [REG_WIDTH-1:0]    dbg_datareq_win_cnt,
    output logic [REG_WIDTH-1:0]    dbg_datareq_stall_cnt
);

    localparam int CW = DIM_WIDTH + 1;

    state_e                  state_q, state_d;
    logic [DIM_WIDTH-1:0]    w_q, h_q, c_q;
    logic [KSIZE_WIDTH-1:0]  k_q;
    logic [STRIDE_WIDTH-1:0] s_q;
    logic [ADDR_WIDTH-1:0]   base_q, pitch_q, hstep_q, vstep_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, line_q, line_d;
    logic [ADDR_WIDTH-1:0]   win_q, win_d, rowwin_q, rowwin_d;
    logic [CW-1:0]           col_q, col_d, row_q, row_d;
    logic                    win_last_q, win_last_d;

    logic                    start_acc, zero_win, col_cont, row_cont, cnt_clr;
    logic [CW-1:0]           s_ext, k_ext;
    logic [DIM_WIDTH-1:0]    c_term, c_nxt;
    logic [KSIZE_WIDTH-1:0]  k_term, kx_nxt, ky_nxt;
    logic                    c_wrap, kx_wrap, ky_wrap;
    logic                    unused_cfg_bits;

    assign unused_cfg_bits = ^{i_conf_inputshape[REG_WIDTH-1:SHAPE_C_OFS+DIM_WIDTH],
                               i_conf_kernelshape[REG_WIDTH-1:KSIZE_WIDTH]};

    assign start_acc = (state_q == ST_IDLE) & i_start & ~i_clear;
    assign o_rden    = (state_q == ST_RUN) & ~i_stall;
    assign o_addr    = addr_q;
    assign o_win_last = win_last_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = (state_q == ST_DONE);

    assign c_term  = c_q - DIM_WIDTH'(1);
    assign k_term  = k_q - KSIZE_WIDTH'(1);
    assign cnt_clr = (state_q != ST_RUN);

    assign zero_win = (k_q == '0) | (c_q == '0) |
                      (DIM_WIDTH'(k_q) > w_q) | (DIM_WIDTH'(k_q) > h_q);

    // Bases are one bit wider than the dimensions, so base+S+K never overflows.
    assign s_ext    = CW'(s_q);
    assign k_ext    = CW'(k_q);
    assign col_cont = (col_q + s_ext + k_ext) <= CW'(w_q);
    assign row_cont = (row_q + s_ext + k_ext) <= CW'(h_q);

    data_req_win_cnt #(.WIDTH(DIM_WIDTH)) u_cnt_c (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(o_rden),
        .term_i(c_term), .nxt_o(c_nxt), .wrap_o(c_wrap)
    );

    data_req_win_cnt #(.WIDTH(KSIZE_WIDTH)) u_cnt_kx (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(c_wrap),
        .term_i(k_term), .nxt_o(kx_nxt), .wrap_o(kx_wrap)
    );

    data_req_win_cnt #(.WIDTH(KSIZE_WIDTH)) u_cnt_ky (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(kx_wrap),
        .term_i(k_term), .nxt_o(ky_nxt), .wrap_o(ky_wrap)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        line_d   = line_q;
        win_d    = win_q;
        rowwin_d = rowwin_q;
        col_d    = col_q;
        row_d    = row_q;
        unique case (state_q)
            ST_IDLE: if (i_start) state_d = ST_CFG0;
            ST_CFG0: state_d = ST_CFG1;
            ST_CFG1: begin
                addr_d   = base_q;
                line_d   = base_q;
                win_d    = base_q;
                rowwin_d = base_q;
                col_d    = '0;
                row_d    = '0;
                state_d  = zero_win ? ST_DONE : ST_RUN;
            end
            ST_RUN: if (o_rden) begin
                if (ky_wrap) begin
                    if (col_cont) begin
                        col_d  = col_q + s_ext;
                        win_d  = win_q + hstep_q;
                        line_d = win_d;
                        addr_d = win_d;
                    end else if (row_cont) begin
                        row_d    = row_q + s_ext;
                        col_d    = '0;
                        rowwin_d = rowwin_q + vstep_q;
                        win_d    = rowwin_d;
                        line_d   = rowwin_d;
                        addr_d   = rowwin_d;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (kx_wrap) begin
                    line_d = line_q + pitch_q;
                    addr_d = line_d;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (i_clear) state_d = ST_IDLE;
        // Flag travels with the address it describes: decode the counters' next position.
        win_last_d = (state_d == ST_RUN) & (c_nxt == c_term) &
                     (kx_nxt == k_term) & (ky_nxt == k_term);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            base_q     <= '0;
            pitch_q    <= '0;
            hstep_q    <= '0;
            vstep_q    <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            win_q      <= '0;
            rowwin_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            win_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            win_q      <= win_d;
            rowwin_q   <= rowwin_d;
            col_q      <= col_d;
            row_q      <= row_d;
            win_last_q <= win_last_d;
            if (start_acc) begin
                w_q    <= i_conf_inputshape[SHAPE_W_OFS +: DIM_WIDTH];
                h_q    <= i_conf_inputshape[SHAPE_H_OFS +: DIM_WIDTH];
                c_q    <= i_conf_inputshape[SHAPE_C_OFS +: DIM_WIDTH];
                k_q    <= i_conf_kernelshape[KSIZE_WIDTH-1:0];
                s_q    <= (i_cnfx_stride == '0) ? STRIDE_WIDTH'(1) : i_cnfx_stride;
                base_q <= i_base_addr;
            end
            if (state_q == ST_CFG0) begin
                pitch_q <= ADDR_WIDTH'(w_q) * ADDR_WIDTH'(c_q);
            end
            if (state_q == ST_CFG1) begin
                hstep_q <= ADDR_WIDTH'(s_q) * ADDR_WIDTH'(c_q);
                vstep_q <= ADDR_WIDTH'(s_q) * pitch_q;
            end
        end
    end

`ifdef DATA_REQ_WIN_DBG_EN
    logic [REG_WIDTH-1:0] win_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            win_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ky_wrap && !(&win_cnt_q)) begin
                win_cnt_q <= win_cnt_q + REG_WIDTH'(1);
            end
            if ((state_q == ST_RUN) && i_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + REG_WIDTH'(1);
            end
        end
    end

    assign dbg_datareq_win_cnt   = win_cnt_q;
    assign dbg_datareq_stall_cnt = stall_cnt_q;
`else
    assign dbg_datareq_win_cnt   = '0;
    assign dbg_datareq_stall_cnt = '0;
`endif

endmodule

// File: doc/data_req_win.md
# data_req_win

Parametrised convolution-window read-request generator that replaces the fixed 3x3, row-stepping request logic in front of the data block RAM. It produces the full address sequence for every output window of a K x K kernel sliding with stride S over an H x W x C feature map stored HWC-contiguous from a base address. Generation honours same-cycle stall backpressure and reports window and job boundaries to the PE array controller.

## Interface
- ADDR_WIDTH, 32, request address width
- REG_WIDTH, 32, configuration and debug register width
- DIM_WIDTH, 8, width of W, H and C fields
- KSIZE_WIDTH, 3, kernel size field width (K up to 7)
- STRIDE_WIDTH, 4, stride field width

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  job start pulse; accepted only in IDLE
- i_clear  in  1  synchronous abort: return to IDLE, no o_done
- i_stall  in  1  backpressure; no request in the cycle it is high
- i_base_addr  in  ADDR_WIDTH  feature map base word address
- i_conf_inputshape  in  REG_WIDTH  [7:0] W, [15:8] H, [23:16] C
- i_conf_kernelshape  in  REG_WIDTH  [KSIZE_WIDTH-1:0] K (square kernel)
- i_cnfx_stride  in  STRIDE_WIDTH  stride S
- o_addr  out  ADDR_WIDTH  request address
- o_rden  out  1  read enable; one word per high cycle
- o_win_last  out  1  qualifies o_rden; last word of the current window
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse at job completion
- dbg_datareq_win_cnt  out  REG_WIDTH  windows completed
- dbg_datareq_stall_cnt  out  REG_WIDTH  cycles in RUN with i_stall high

## Operation
- States: IDLE, CFG0, CFG1, RUN, DONE.
- IDLE -> CFG0 on i_start. Shape, kernel, stride and base are latched on the i_start cycle. Later input changes are ignored until the next job.
- CFG0: compute pitch = W*C. This is the only full multiply in the block.
- CFG1: compute hstep = S*C and vstep = S*pitch.
- Zero-window job: K=0, C=0, K>W or K>H. CFG1 -> DONE with no requests.
- Otherwise CFG1 -> RUN with o_addr = base.
- S=0 is treated as S=1.
- Loop order, innermost first: channel c, kernel column kx, kernel row ky, window column, window row.
- Step rules (adders only):
  - Within a kernel row: o_addr +1.
  - End of kernel row: line_addr += pitch; o_addr follows.
  - End of window: win_addr += hstep.
  - End of window row: rowwin_addr += vstep; win_addr = rowwin_addr.
- Window-column continuation: next column exists iff col_base+S+K <= W. Window-row continuation is the same test with H. No division is used.
- Column and row bases are DIM_WIDTH+1 bits wide so the test cannot overflow.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Total requests = OW*OH*K*K*C.
- RUN -> DONE after the request that has o_win_last high in the last window.
- DONE -> IDLE after one cycle; o_done is high during DONE.
- i_clear in any state goes to IDLE next cycle; no o_done is produced.
- i_start while busy is ignored.
- i_clear and i_start in the same cycle: i_clear wins.

## Timing
- Reset: state IDLE; o_addr=0, o_rden=0, o_win_last=0, o_busy=0, o_done=0; all counters 0.
- i_start at cycle t: CFG0 at t+1, CFG1 at t+2, first possible request at t+3.
- o_rden = (state==RUN) & ~i_stall. This is combinational on i_stall, with zero-cycle stall response.
- o_addr and o_win_last are registered. They hold their value while stalled and advance only on cycles where o_rden is high.
- o_done is high at cycle L+1, where L is the cycle of the last request.
- Reset asserted mid-job aborts immediately to the reset state.

## Configuration
- DATA_REQ_WIN_DBG_EN defined: dbg_datareq_win_cnt and dbg_datareq_stall_cnt are live.
  - Both clear on i_start.
  - Both saturate at all-ones.
- DATA_REQ_WIN_DBG_EN undefined: both debug outputs are tied to 0 and the counters are not built. The ports remain present.

## Structure
- A shared package holds:
  - the state encoding;
  - inputshape field offsets (W 0, H 8, C 16);
  - a common address type.
- One sub-module, data_req_win_cnt: a generic wrap counter with enable, terminal value and wrap flag. It is instantiated for c, kx and ky. Window position stays in the top level.

## Test plan
- W=4, H=4, C=1, K=3, S=1, base=0, no stall:
  - 36 requests; first window 0,1,2,4,5,6,8,9,10; second window starts at 1;
  - o_win_last on every 9th request; o_done one cycle after the 36th.
- W=5, H=5, C=2, K=3, S=2, base=100:
  - 4 windows starting at 100, 104, 120, 124; 18 words each.
- Same job as the first scenario with i_stall high on alternate cycles:
  - identical address sequence;
  - no o_rden in any stalled cycle;
  - stall counter equals the number of stalled RUN cycles when DATA_REQ_WIN_DBG_EN is defined.
- K=3, W=2 (zero-window job):
  - o_rden never asserts; o_done at t+3.
- i_clear during the second window:
  - IDLE next cycle, no o_done;
  - a new i_start restarts at the new base.
- rst_n low mid-RUN:
  - all outputs take reset values asynchronously;
  - after release, no request until i_start.
